// File: rtl/multdiv_arbiter.sv
// multdiv_arbiter
//   Round-robin front end for the shared multiply/divide unit. Two requesters
//   hand over MULT/DIV operations with a valid/ready handshake. One operation
//   is outstanding at a time. The block holds the operands stable on the unit,
//   pulses the start control, waits for a rising edge on md_resultRDY, and
//   returns the result and exception to the owner as a one-cycle pulse. If the
//   unit never completes, the owner receives a forced exception response.
//
// Ports
//   clock, reset_n                  rising-edge clock, synchronous active-low reset
//   req_valid_x/req_op_x/req_a_x/req_b_x   request from requester x (op 0=MULT, 1=DIV)
//   req_ready_x                     combinational accept (only in IDLE, granted port)
//   rsp_valid_x                     one-cycle response pulse to requester x
//   rsp_result, rsp_exception       response payload, valid with rsp_valid_x
//   busy                            high whenever an operation is in flight
//   md_operandA/B, md_ctrl_MULT/DIV operands and start pulses to the unit
//   md_result/md_exception/md_resultRDY    unit result interface
module multdiv_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid_0,
  input  logic        req_op_0,
  input  logic [31:0] req_a_0,
  input  logic [31:0] req_b_0,
  output logic        req_ready_0,
  input  logic        req_valid_1,
  input  logic        req_op_1,
  input  logic [31:0] req_a_1,
  input  logic [31:0] req_b_1,
  output logic        req_ready_1,
  output logic        rsp_valid_0,
  output logic        rsp_valid_1,
  output logic [31:0] rsp_result,
  output logic        rsp_exception,
  output logic        busy,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  logic          last_grant;
  logic          owner;
  logic          rdy_q;
  logic [CW-1:0] count;
  logic          grant;
  logic          grant_op;
  logic          accept;
  logic          rdy_rise;

  // Lone requester always wins; on contention the one not granted last wins.
  always_comb begin
    grant = req_valid_1;
    if (req_valid_0 && req_valid_1) begin
      grant = ~last_grant;
    end
    grant_op = grant ? req_op_1 : req_op_0;
  end

  assign accept      = reset_n && (state == IDLE) && (req_valid_0 || req_valid_1);
  assign req_ready_0 = accept && !grant;
  assign req_ready_1 = accept && grant;

  // Completion is a fresh low-to-high transition; a level left over from the
  // previous operation does not count.
  assign rdy_rise = md_resultRDY && !rdy_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      owner         <= 1'b0;
      rdy_q         <= 1'b0;
      count         <= '0;
      rsp_valid_0   <= 1'b0;
      rsp_valid_1   <= 1'b0;
      rsp_result    <= '0;
      rsp_exception <= 1'b0;
      busy          <= 1'b0;
      md_operandA   <= '0;
      md_operandB   <= '0;
      md_ctrl_MULT  <= 1'b0;
      md_ctrl_DIV   <= 1'b0;
    end else begin
      rdy_q        <= md_resultRDY;
      md_ctrl_MULT <= 1'b0;
      md_ctrl_DIV  <= 1'b0;
      rsp_valid_0  <= 1'b0;
      rsp_valid_1  <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            owner       <= grant;
            last_grant  <= grant;
            md_operandA <= grant ? req_a_1 : req_a_0;
            md_operandB <= grant ? req_b_1 : req_b_0;
            // Start pulse is registered here so it is high exactly during ISSUE.
            md_ctrl_MULT <= !grant_op;
            md_ctrl_DIV  <= grant_op;
            busy         <= 1'b1;
            state        <= ISSUE;
          end
        end

        ISSUE: begin
          count <= '0;
          state <= WAIT;
        end

        WAIT: begin
          if (rdy_rise) begin
            rsp_result    <= md_result;
            rsp_exception <= md_exception;
            rsp_valid_0   <= !owner;
            rsp_valid_1   <= owner;
            state         <= RESP;
          end else if (count == CW'(TIMEOUT_CYCLES)) begin
            rsp_result    <= '0;
            rsp_exception <= 1'b1;
            rsp_valid_0   <= !owner;
            rsp_valid_1   <= owner;
            state         <= RESP;
          end else begin
            count <= count + 1'b1;
          end
        end

        RESP: begin
          rsp_result    <= '0;
          rsp_exception <= 1'b0;
          md_operandA   <= '0;
          md_operandB   <= '0;
          busy          <= 1'b0;
          state         <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_arbiter.sv
// Testbench for multdiv_arbiter: directed sequence with a behavioural
// multiply/divide unit and a response scoreboard.
module tb_multdiv_arbiter;

  localparam int TO = 64;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid_0 = 1'b0, req_op_0 = 1'b0;
  logic [31:0] req_a_0 = '0, req_b_0 = '0;
  logic        req_ready_0;
  logic        req_valid_1 = 1'b0, req_op_1 = 1'b0;
  logic [31:0] req_a_1 = '0, req_b_1 = '0;
  logic        req_ready_1;
  logic        rsp_valid_0, rsp_valid_1;
  logic [31:0] rsp_result;
  logic        rsp_exception;
  logic        busy;
  logic [31:0] md_operandA, md_operandB;
  logic        md_ctrl_MULT, md_ctrl_DIV;
  logic [31:0] md_result = '0;
  logic        md_exception = 1'b0;
  logic        md_resultRDY = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Unit model controls: latency (0 = never completes), keep RDY high across
  // the start pulse, and the countdown value at which a held RDY drops.
  int u_lat = 1;
  bit u_hold = 1'b0;
  int u_drop = 0;
  int u_cnt = 0;
  bit u_div = 1'b0;

  typedef struct {
    int          port;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  multdiv_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid_0(req_valid_0), .req_op_0(req_op_0), .req_a_0(req_a_0),
    .req_b_0(req_b_0), .req_ready_0(req_ready_0),
    .req_valid_1(req_valid_1), .req_op_1(req_op_1), .req_a_1(req_a_1),
    .req_b_1(req_b_1), .req_ready_1(req_ready_1),
    .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
    .rsp_result(rsp_result), .rsp_exception(rsp_exception), .busy(busy),
    .md_operandA(md_operandA), .md_operandB(md_operandB),
    .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
    .md_result(md_result), .md_exception(md_exception),
    .md_resultRDY(md_resultRDY)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    if (md_ctrl_MULT || md_ctrl_DIV) begin
      u_div <= md_ctrl_DIV;
      u_cnt <= u_lat;
      if (!u_hold) md_resultRDY <= 1'b0;
    end else if (u_cnt != 0) begin
      u_cnt <= u_cnt - 1;
      if (u_cnt == 1) begin
        md_resultRDY <= 1'b1;
        if (u_div) begin
          md_result    <= (md_operandB == '0) ? '0 : md_operandA / md_operandB;
          md_exception <= (md_operandB == '0);
        end else begin
          md_result    <= md_operandA * md_operandB;
          md_exception <= 1'b0;
        end
      end else if (u_drop != 0 && u_cnt == u_drop) begin
        md_resultRDY <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ready0"}, 32'(req_ready_0), 32'd0);
    chk({tag, "_ready1"}, 32'(req_ready_1), 32'd0);
    chk({tag, "_rsp"}, 32'({rsp_valid_1, rsp_valid_0}), 32'd0);
    chk({tag, "_result"}, rsp_result, 32'd0);
    chk({tag, "_exc"}, 32'(rsp_exception), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_opA"}, md_operandA, 32'd0);
    chk({tag, "_opB"}, md_operandB, 32'd0);
    chk({tag, "_ctrl"}, 32'({md_ctrl_DIV, md_ctrl_MULT}), 32'd0);
  endtask

  // Called at a falling edge with the DUT in IDLE. exp_lat = 0 means a
  // forced timeout response is expected. keep = 1 leaves the requests
  // pending; keep = 0 withdraws both ports and scrambles this port's operands.
  task automatic op(input int port, input logic opc, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] res,
                    input logic exc, input int exp_lat, input bit keep);
    exp_t e;
    bit   got;
    int   n;
    if (port == 0) begin
      req_op_0 = opc; req_a_0 = a; req_b_0 = b; req_valid_0 = 1'b1;
    end else begin
      req_op_1 = opc; req_a_1 = a; req_b_1 = b; req_valid_1 = 1'b1;
    end
    #1;
    chk("grant_ready", 32'({req_ready_1, req_ready_0}), (port == 0) ? 32'd1 : 32'd2);
    @(posedge clock);
    #1;
    n = cyc;
    e.port = port; e.a = a; e.b = b; e.res = res; e.exc = exc;
    e.cyc = (exp_lat == 0) ? n + TO + 2 : n + 2 + exp_lat;
    sb.push_back(e);
    if (!keep) begin
      req_valid_0 = 1'b0;
      req_valid_1 = 1'b0;
      if (port == 0) begin
        req_a_0 = 32'hDEADBEEF; req_b_0 = 32'h12345678;
      end else begin
        req_a_1 = 32'hCAFEF00D; req_b_1 = 32'h87654321;
      end
    end
    @(negedge clock);
    chk("issue_mult", 32'(md_ctrl_MULT), 32'(!opc));
    chk("issue_div", 32'(md_ctrl_DIV), 32'(opc));
    chk("issue_busy", 32'(busy), 32'd1);
    chk("issue_opA", md_operandA, a);
    chk("issue_opB", md_operandB, b);
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      chk("hold_opA", md_operandA, sb[0].a);
      chk("hold_opB", md_operandB, sb[0].b);
      if (rsp_valid_0 || rsp_valid_1) begin
        e = sb.pop_front();
        chk("rsp_port", 32'({rsp_valid_1, rsp_valid_0}), (e.port == 0) ? 32'd1 : 32'd2);
        chk("rsp_result", rsp_result, e.res);
        chk("rsp_exc", 32'(rsp_exception), 32'(e.exc));
        chk("rsp_cycle", cyc, e.cyc);
        chk("rsp_busy", 32'(busy), 32'd1);
        got = 1'b1;
        break;
      end
    end
    chk("rsp_seen", 32'(got), 32'd1);
    @(negedge clock);
    chk("post_rsp", 32'({rsp_valid_1, rsp_valid_0}), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_opA", md_operandA, 32'd0);
  endtask

  initial begin
    int seen;

    // Reset state
    repeat (3) @(negedge clock);
    chk_quiet("reset");
    reset_n = 1'b1;

    // Single multiply on port 0
    u_lat = 33; u_hold = 1'b0; u_drop = 0;
    op(0, 1'b0, 32'd7, 32'd6, 32'd42, 1'b0, 33, 1'b0);

    // RDY still high from the previous op: only the fresh edge completes
    u_lat = 20; u_hold = 1'b1; u_drop = 10;
    op(0, 1'b0, 32'd11, 32'd13, 32'd143, 1'b0, 20, 1'b0);

    // RDY held high across ISSUE and never dropping: times out
    u_lat = 20; u_hold = 1'b1; u_drop = 0;
    op(1, 1'b1, 32'd40, 32'd8, 32'd0, 1'b1, 0, 1'b0);

    // Unit never completes: forced exception response
    u_lat = 0; u_hold = 1'b0; u_drop = 0;
    op(0, 1'b0, 32'd2, 32'd2, 32'd0, 1'b1, 0, 1'b0);

    // Both ports valid straight out of reset: strict alternation 0,1,0,1
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    u_lat = 8;
    req_op_1 = 1'b0; req_a_1 = 32'd3; req_b_1 = 32'd5; req_valid_1 = 1'b1;
    op(0, 1'b1, 32'd100, 32'd7, 32'd14, 1'b0, 8, 1'b1);
    op(1, 1'b0, 32'd3, 32'd5, 32'd15, 1'b0, 8, 1'b1);
    op(0, 1'b1, 32'd100, 32'd7, 32'd14, 1'b0, 8, 1'b1);
    op(1, 1'b0, 32'd3, 32'd5, 32'd15, 1'b0, 8, 1'b0);

    // Divide by zero on port 1 (lone requester wins although granted last)
    u_lat = 10;
    op(1, 1'b1, 32'd5, 32'd0, 32'd0, 1'b1, 10, 1'b0);

    // Reset pulse mid-WAIT abandons the operation silently
    u_lat = 40;
    req_op_1 = 1'b0; req_a_1 = 32'd9; req_b_1 = 32'd9; req_valid_1 = 1'b1;
    #1;
    chk("abort_ready", 32'(req_ready_1), 32'd1);
    @(posedge clock);
    #1;
    req_valid_1 = 1'b0;
    repeat (10) @(negedge clock);
    chk("abort_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    chk_quiet("abort");
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (rsp_valid_0 || rsp_valid_1 || busy) seen++;
    end
    chk("abort_no_rsp", seen, 32'd0);

    // Normal operation after the abort
    u_lat = 5;
    op(0, 1'b0, 32'd6, 32'd7, 32'd42, 1'b0, 5, 1'b0);

    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multdiv_arbiter.md
# multdiv_arbiter

Sequencer and two-port arbiter for the shared multiply/divide unit. Two requesters (e.g. execute stage and a coprocessor port) submit MULT/DIV operations through a valid/ready handshake. The block grants one at a time round-robin, holds operands stable and pulses the unit's start control. It detects completion, returns result and exception to the owning requester, and forces an exception response if the unit never reports ready.

## Interface
- TIMEOUT_CYCLES, 64: WAIT cycles without completion before a forced exception response (must be ≥ 40).
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req_valid_0 / req_valid_1  in  1  requester has an operation pending.
- req_op_0 / req_op_1  in  1  0 = multiply, 1 = divide.
- req_a_0, req_b_0 / req_a_1, req_b_1  in  32  operands A and B.
- req_ready_0 / req_ready_1  out  1  request accepted this cycle (valid & ready = transfer).
- rsp_valid_0 / rsp_valid_1  out  1  one-cycle response pulse to that requester.
- rsp_result  out  32  result, valid while any rsp_valid_x is high.
- rsp_exception  out  1  exception flag, valid with rsp_valid_x.
- busy  out  1  high in every state except IDLE.
- md_operandA, md_operandB  out  32  operands to the unit.
- md_ctrl_MULT, md_ctrl_DIV  out  1  one-cycle start pulses to the unit.
- md_result  in  32  unit result.
- md_exception  in  1  unit exception.
- md_resultRDY  in  1  unit result ready.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant goes to a requester with req_valid high. If both are valid, the requester not granted last wins.
  - After reset, requester 0 has priority.
  - req_ready_x is combinational: high only in IDLE, and only for the granted requester.
  - On transfer, register the op, A, B and owner; update the last-grant pointer; go to ISSUE.
- ISSUE (exactly one cycle):
  - Assert md_ctrl_MULT if op = 0, otherwise md_ctrl_DIV. Never assert both.
  - Clear the timeout counter; go to WAIT.
- WAIT:
  - Completion is a rising edge of md_resultRDY: high this cycle and low the previous cycle.
  - The RDY delay register samples every cycle in all states.
  - On completion, capture md_result and md_exception; go to RESP.
  - The counter increments each WAIT cycle. If it reaches TIMEOUT_CYCLES with no completion, capture result 0 and exception 1; go to RESP.
- RESP:
  - Pulse rsp_valid for the owner only; drive the captured result and exception.
  - There is no backpressure: the requester must take the response in this cycle.
  - Return to IDLE.
- md_operandA/B are driven from registered operands from ISSUE through RESP, and are 0 in IDLE. The unit samples operands throughout its iteration, so they must not change mid-operation.
- Requests are not queued; only one operation is outstanding.
- The block performs no arithmetic. Widths pass through unchanged: 32-bit result, 1-bit exception.

## Timing
- Reset values: state IDLE, all outputs 0, last-grant pointer = 1 (so requester 0 wins first), counter 0, RDY delay register 0.
- Cycle numbering from a transfer at edge N:
  - N+1: ISSUE, md_ctrl pulse.
  - N+2: first WAIT cycle.
  - If the RDY edge is seen in cycle M, RESP occurs in cycle M+1.
  - busy is high from N+1 through RESP.
- Minimum turnaround is 4 cycles per operation; the next transfer can occur in the cycle after RESP.
- Simultaneous valid on both requesters: alternate strictly. A requester that drops req_valid before it is granted loses nothing.
- md_resultRDY high during ISSUE or IDLE is ignored. If RDY stays high across ISSUE, no edge is seen and the operation times out.
- Reset mid-operation:
  - Abandon immediately; no response pulse to the owner; all outputs return to reset values the following cycle.
  - The unit is not reset; the next start pulse restarts it.
- A timeout response occurs in the cycle after the counter reaches TIMEOUT_CYCLES, i.e. TIMEOUT_CYCLES + 3 cycles after transfer.

## Test plan
- Single multiply on port 0, A=7, B=6, unit returns 42 after 33 cycles → req_ready_0 at transfer, md_ctrl_MULT pulse for one cycle, rsp_valid_0 one cycle with 42, exception 0, rsp_valid_1 stays 0.
- Both ports valid from reset: port 0 DIV 100/7, port 1 MULT 3×5 → port 0 granted first (result 14), then port 1 (result 15). Grants alternate over 4 back-to-back operations.
- Divide by zero on port 1, A=5, B=0, unit asserts exception → rsp_valid_1 with rsp_exception 1.
- Unit never raises md_resultRDY, TIMEOUT_CYCLES = 64 → rsp_valid pulse at transfer+67 with result 0 and exception 1; busy drops the next cycle.
- reset_n low for one cycle mid-WAIT → no rsp_valid, all outputs 0, state IDLE. A new request afterwards completes normally.
- md_resultRDY held high entering ISSUE → completion only on a fresh low-to-high transition. Operands stay unchanged on md_operandA/B for the entire operation even if req_a/b change.
